uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that takes a parallel word over a valid/ready handshake and shifts it out on a single line as a framed bit stream: start bit, data LSB first, optional even parity bit, stop bit, with each bit held for a fixed number of clock cycles. It is the sending end of the single-bit serial link whose receiver consumes `serial_out`. It sits between a producer, such as a CPU MMIO register or FIFO, and the off-chip serial pin. The line idles high.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (≥1)
- `CLKS_PER_BIT`, 16, clock cycles per serial bit (≥2)
- `PARITY_EN`, 0, 1 inserts an even-parity bit after the data bits

- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset; one clock, reset sampled on posedge
- `data_in`  in  DATA_WIDTH  word to transmit, sampled only at handshake
- `data_in_valid`  in  1  producer has a word
- `data_in_ready`  out  1  transmitter can accept a word (registered)
- `serial_out`  out  1  serial line, idle high (registered)

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: a word is accepted on a posedge where `data_in_valid && data_in_ready`. `data_in` is latched into a shift register at that edge. Later changes to `data_in` have no effect on the frame.
- IDLE: `data_in_ready`=1, `serial_out`=1. On handshake go to START and drop `data_in_ready`.
- START: `serial_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `serial_out` = current LSB of the shift register. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After DATA_WIDTH bits go to PARITY if PARITY_EN, else STOP.
- PARITY: `serial_out` = XOR of all latched data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `serial_out`=1 for CLKS_PER_BIT cycles, then go to IDLE and raise `data_in_ready`.
- `data_in_valid` asserted outside IDLE is ignored: no latch, no state change.
- Counters:
  - Cycle counter, $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1. It wraps to 0 at each bit boundary.
  - Bit index, $clog2(DATA_WIDTH)+1 bits, counts 0..DATA_WIDTH-1 in DATA.
  - Both counters clear on reset and on handshake.
- Default case (illegal state encoding) goes to IDLE with `serial_out`=1.
- Reset has priority over every other event, including a handshake in the same cycle.
  - Reset mid-frame aborts the frame and discards the word.
  - After the reset edge: state IDLE, `serial_out`=1, `data_in_ready`=1, counters 0.

## Timing
- Outputs are registered, so there is no combinational path from `data_in_valid` to `data_in_ready`.
- Frame length F = (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles.
- Handshake at edge k:
  - `serial_out` goes low in the cycle after edge k, i.e. it is 0 for cycles k+1 … k+CLKS_PER_BIT.
  - Data bit i occupies cycles k+1+(1+i)·CLKS_PER_BIT onward.
- Stop bit ends after cycle k+F. `data_in_ready` returns to 1 in cycle k+F+1.
- Back-to-back: with `data_in_valid` held high, successive start bits are F+1 cycles apart. The one idle-high cycle between frames is required.

## Test plan
- Reset: assert `rst` for 2 cycles mid-stream → after release, `serial_out`=1 and `data_in_ready`=1. Line stays high with `data_in_valid`=0 for 100 cycles.
- Single frame, CLKS_PER_BIT=4, PARITY_EN=0, `data_in`=8'hA5:
  - Line sequence per bit is 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles (40 cycles total).
  - `data_in_ready` is low for 40 cycles.
- Parity, PARITY_EN=1:
  - 8'hA5 → parity bit 0, 11 bits / 44 cycles.
  - 8'h07 → parity bit 1.
- Back-to-back: hold valid with words 8'h00 then 8'hFF → start bits are exactly 41 cycles apart. Both frames decode correctly via a bench-side receiver model.
- Busy / data stability:
  - Pulse `data_in_valid` with 8'h3C during the DATA state of an 8'hA5 frame → ignored, 8'hA5 is sent intact.
  - Changing `data_in` after the handshake does not alter the frame.
- Reset mid-frame: assert `rst` during data bit 3 → `serial_out`=1 and `data_in_ready`=1 the cycle after the reset edge. A fresh handshake of 8'h5A then produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/uart_tx.sv
// Framed serial transmitter: start, LSB-first data, optional even parity, stop.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus,
    output logic     serial_out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  parity;
    logic                  ready;
    logic                  hs;
    logic                  bit_done;

    assign bus.data_in_ready = ready;
    assign hs       = (state == IDLE) && ready && bus.data_in_valid;
    assign bit_done = (cnt == CNT_LAST);
    assign shifted  = shreg >> 1;

    // serial_out is loaded one state ahead so the line changes on the bit edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            ready      <= 1'b1;
            serial_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    ready      <= 1'b1;
                    if (hs) begin
                        state      <= START;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        shreg      <= bus.data_in;
                        parity     <= ^bus.data_in;
                        ready      <= 1'b0;
                        serial_out <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt        <= '0;
                        state      <= DATA;
                        serial_out <= shreg[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        shreg <= shifted;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state      <= PARITY;
                                serial_out <= parity;
                            end else begin
                                state      <= STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            serial_out <= shifted[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        cnt        <= '0;
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt        <= '0;
                        state      <= IDLE;
                        ready      <= 1'b1;
                        serial_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    bit_idx    <= '0;
                    ready      <= 1'b1;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Two transmitters (parity off / on) against a frame-timing model and a line receiver.
module tb_uart_tx;
    localparam int C  = 4;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din [2];
    logic [1:0] vin = '0;
    logic [1:0] line;
    logic [1:0] rdy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    logic [1:0] busy  = '0;
    logic       armed = 1'b0;
    int         cyc  [2] = '{0, 0};
    logic [7:0] word [2] = '{8'h00, 8'h00};
    int         hs   [2] = '{0, 0};
    logic [7:0] expq [2][$];
    int         starts [2][$];

    logic [1:0]  rx_act = '0;
    int          rx_t0   [2] = '{0, 0};
    logic [11:0] rx_bits [2] = '{12'h0, 12'h0};

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8)) bus0 ();
    uart_tx_if #(.DATA_WIDTH(8)) bus1 ();

    assign bus0.data_in       = din[0];
    assign bus0.data_in_valid = vin[0];
    assign rdy[0]             = bus0.data_in_ready;
    assign bus1.data_in       = din[1];
    assign bus1.data_in_valid = vin[1];
    assign rdy[1]             = bus1.data_in_ready;

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0), .serial_out(line[0])
    );
    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1), .serial_out(line[1])
    );

    function automatic int flen(input int pe);
        return (2 + DW + pe) * C;
    endfunction

    function automatic logic fbit(input int pe, input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (pe != 0 && b == DW + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic void chk(input string nm, input int d, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            if (n_bad < 40)
                $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d",
                         nm, d, cyc_n, act, exp);
            n_bad++;
        end
    endfunction

    // reference model: a handshake makes the line busy for exactly one frame
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rst) armed <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy[d] <= 1'b0;
                cyc[d]  <= 0;
                expq[d].delete();
            end else if (busy[d]) begin
                if (cyc[d] + 1 == flen(d)) busy[d] <= 1'b0;
                cyc[d] <= cyc[d] + 1;
            end else if (vin[d]) begin
                busy[d] <= 1'b1;
                cyc[d]  <= 0;
                word[d] <= din[d];
                expq[d].push_back(din[d]);
                hs[d]   <= hs[d] + 1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic        el;
        int          rel;
        int          b;
        int          nb;
        logic [11:0] bv;
        logic [7:0]  ew;
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                el = busy[d] ? fbit(d, word[d], cyc[d] / C) : 1'b1;
                chk("line", d, int'(line[d]), int'(el));
                chk("ready", d, int'(rdy[d]), int'(!busy[d]));
                nb = 2 + DW + d;
                if (rst) begin
                    rx_act[d] <= 1'b0;
                end else if (!rx_act[d]) begin
                    if (line[d] == 1'b0) begin
                        rx_act[d] <= 1'b1;
                        rx_t0[d]  <= cyc_n;
                        starts[d].push_back(cyc_n);
                    end
                end else begin
                    rel = cyc_n - rx_t0[d];
                    if (rel % C == C / 2) begin
                        b = rel / C;
                        bv = rx_bits[d];
                        bv[b] = line[d];
                        rx_bits[d] <= bv;
                        if (b == nb - 1) begin
                            rx_act[d] <= 1'b0;
                            if (expq[d].size() == 0) begin
                                chk("unexpected_frame", d, 1, 0);
                            end else begin
                                ew = expq[d].pop_front();
                                chk("start_bit", d, int'(bv[0]), 0);
                                chk("data", d, int'(bv[8:1]), int'(ew));
                                if (d == 1) chk("parity", d, int'(bv[9]), int'(^ew));
                                chk("stop_bit", d, int'(bv[nb-1]), 1);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy != 2'b00 && n < 400) begin
            tick();
            n++;
        end
        if (busy != 2'b00) chk("idle_timeout", 0, 0, 1);
        repeat (3) tick();
    endtask

    task automatic send_both(input logic [7:0] w);
        din[0] = w;
        din[1] = w;
        vin    = 2'b11;
        tick();
        vin    = 2'b00;
        din[0] = 8'($urandom);
        din[1] = 8'($urandom);
    endtask

    task automatic b2b(input int d);
        int h;
        int n;
        din[d] = 8'h00;
        vin[d] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            h = hs[d];
            n = 0;
            while (hs[d] == h && n < 200) begin
                tick();
                n++;
            end
            if (hs[d] == h) chk("b2b_timeout", d, 0, 1);
            din[d] = 8'hFF;
        end
        vin[d] = 1'b0;
    endtask

    initial begin
        din[0] = 8'h00;
        din[1] = 8'h00;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, int'(rdy[d]), 1);
            chk("rst_line", d, int'(line[d]), 1);
        end
        repeat (100) tick();

        send_both(8'hA5);
        wait_idle();
        send_both(8'h07);
        wait_idle();

        send_both(8'($urandom));
        repeat (10) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_ready", d, int'(rdy[d]), 1);
            chk("midrst_line", d, int'(line[d]), 1);
        end
        repeat (100) tick();

        starts[0].delete();
        starts[1].delete();
        fork
            b2b(0);
            b2b(1);
        join
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            if (starts[d].size() >= 2)
                chk("b2b_gap", d, starts[d][1] - starts[d][0], flen(d) + 1);
            else
                chk("b2b_starts", d, starts[d].size(), 2);
        end

        send_both(8'hA5);
        repeat (20) tick();
        din[0] = 8'h3C;
        din[1] = 8'h3C;
        vin    = 2'b11;
        tick();
        vin    = 2'b00;
        wait_idle();

        send_both(8'($urandom));
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("bit3rst_ready", d, int'(rdy[d]), 1);
            chk("bit3rst_line", d, int'(line[d]), 1);
        end
        send_both(8'h5A);
        wait_idle();

        repeat (3000) begin
            vin    = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            din[0] = 8'($urandom);
            din[1] = 8'($urandom);
            tick();
        end
        vin = 2'b00;
        wait_idle();
        repeat (5) tick();
        for (int d = 0; d < 2; d++) begin
            chk("queue_empty", d, expq[d].size(), 0);
            chk("rx_idle", d, int'(rx_act[d]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
